pc_fetch: RTL and testbench

- Owns the architectural PC register; consumes the next-PC value and redirect strobe from the next-PC logic.
- Issues instruction-memory requests with a valid/ready handshake and buffers returned words with their PCs.
- Delivers the buffered {pc, inst} pairs to decode with a valid/ready handshake.
- Sits between the next-PC logic, instruction memory and decode; the consumer of the next-PC value and the producer of the PC it is computed from.

---
 rtl/pc_fetch_if.sv | 26 ++
 rtl/pc_fetch.sv | 159 +++++++++++++++
 tb/tb_pc_fetch.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-unit bus bundle: next-PC redirect, instruction-memory request/response, decode delivery.
// master = pc_fetch side, slave = surrounding pipeline/memory side.
interface pc_fetch_if;
  logic [31:0] npc_in;
  logic        npc_load;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;

  modport master (
    input  npc_in, npc_load, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_err
  );

  modport slave (
    output npc_in, npc_load, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_err
  );
endinterface

// File: rtl/pc_fetch.sv
// PC register + single-outstanding imem fetch + DEPTH-entry {pc,inst} buffer; rsp->inst_valid 1 cycle,
// requests stall while buffered+outstanding words would exceed DEPTH. Option macro: PC_FETCH_ALIGN_CHK_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  pc_fetch_if.master bus
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [CW-1:0] count, count_nxt;
  entry_t        fifo_q   [DEPTH];
  entry_t        fifo_nxt [DEPTH];
  logic [AW-1:0] wr_idx;
  logic          run;
  logic          err;
  logic          req_vld;
  logic          req_hs;
  logic          push;
  logic          pop;
  logic          flush;
  logic [31:0]   npc_aligned;

`ifdef PC_FETCH_ALIGN_CHK_EN
  // Sticky: once a misaligned target is seen, fetch stays parked until reset.
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (bus.npc_load && (bus.npc_in[1:0] != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign npc_aligned = bus.npc_in & 32'hFFFF_FFFC;

  // The request itself reserves a buffer slot, so a response can always be pushed.
  assign req_vld = run && !err && (state == REQ) && (count < DEPTH_C);
  assign req_hs  = req_vld && bus.imem_req_ready;
  assign pop     = (count != '0) && bus.inst_ready;
  assign flush   = bus.npc_load;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;

    if (req_hs) begin
      fetch_pc_nxt = fetch_pc + 32'd4;
    end

    case (state)
      REQ: begin
        if (req_hs) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          push      = 1'b1;
          state_nxt = REQ;
        end
      end
      DROP: begin
        if (bus.imem_rsp_valid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase

    // Redirect wins: any in-flight word belongs to the old path and must be discarded.
    if (bus.npc_load) begin
      fetch_pc_nxt = npc_aligned;
      push         = 1'b0;
      if (state == REQ) begin
        state_nxt = req_hs ? DROP : REQ;
      end else begin
        state_nxt = bus.imem_rsp_valid ? REQ : DROP;
      end
    end
  end

  // Shift-register buffer: entry 0 is the head, so decode outputs come straight from flops.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      fifo_nxt[i] = fifo_q[i];
    end
    count_nxt = count;
    wr_idx    = count[AW-1:0] - AW'(pop);

    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fifo_nxt[i] = fifo_q[i + 1];
      end
      count_nxt = count - CW'(1);
    end

    if (push) begin
      fifo_nxt[wr_idx] = '{pc: fetch_pc - 32'd4, inst: bus.imem_rsp_data};
      count_nxt        = count_nxt + CW'(1);
    end

    if (flush) begin
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      count    <= '0;
      run      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      count    <= count_nxt;
      run      <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_nxt[i];
      end
    end
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_addr      = fetch_pc;
  assign bus.inst_valid     = (count != '0);
  assign bus.inst           = fifo_q[0].inst;
  assign bus.inst_pc        = fifo_q[0].pc;
  assign bus.fetch_err      = err;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count == DEPTH_C)));

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: memory model answers with the request address after rsp_delay extra cycles.
module tb_pc_fetch;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_if bus();

  pc_fetch #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] reqlog[$];
  logic [31:0] rx_pc[$];
  logic [31:0] rx_inst[$];
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          rsp_delay = 0;
  logic        last_hs = 1'b0;
  logic [31:0] last_hs_addr = '0;
  int          n_before;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, drive the memory response after the rising edge.
  task automatic cyc();
    logic        hs_now;
    logic [31:0] a_now;
    @(negedge clk);
    hs_now = bus.imem_req_valid && bus.imem_req_ready;
    a_now  = bus.imem_addr;
    if (hs_now) reqlog.push_back(a_now);
    if (bus.inst_valid && bus.inst_ready) begin
      rx_pc.push_back(bus.inst_pc);
      rx_inst.push_back(bus.inst);
    end
    @(posedge clk);
    #1;
    last_hs      = hs_now;
    last_hs_addr = a_now;
    bus.imem_rsp_valid = 1'b0;
    if (hs_now) begin
      pend      = 1'b1;
      pend_addr = a_now;
      pend_cnt  = rsp_delay;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = pend_addr;
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.npc_load = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    pend = 1'b0;
    last_hs = 1'b0;
    reqlog.delete();
    rx_pc.delete();
    rx_inst.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int budget = 80;
    while (rx_pc.size() < n && budget > 0) begin
      cyc();
      budget--;
    end
    check(tag, 32'(rx_pc.size() >= n), 32'd1);
  endtask

  task automatic wait_reqs(input int n, input string tag);
    int budget = 80;
    while (reqlog.size() < n && budget > 0) begin
      cyc();
      budget--;
    end
    check(tag, 32'(reqlog.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input logic [31:0] a, input string tag);
    int budget = 40;
    while (!(bus.imem_req_valid && bus.imem_addr == a) && budget > 0) begin
      cyc();
      budget--;
    end
    check(tag, bus.imem_addr, a);
  endtask

  task automatic wait_hs(input logic [31:0] a, input string tag);
    int budget = 40;
    while (!(last_hs && last_hs_addr == a) && budget > 0) begin
      cyc();
      budget--;
    end
    check(tag, last_hs_addr, a);
  endtask

  initial begin
    bus.npc_in = '0;
    bus.npc_load = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.inst_ready = 1'b1;

    // Async reset before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h3000);

    // Streaming, 1-cycle memory.
    rsp_delay = 0;
    do_reset();
    check("t1_first_req_vld", 32'(bus.imem_req_valid), 32'd1);
    check("t1_first_addr", bus.imem_addr, 32'h3000);
    cyc();
    check("t1_rsp_cycle_empty", 32'(bus.inst_valid), 32'd0);
    cyc();
    check("t1_lat_valid", 32'(bus.inst_valid), 32'd1);
    check("t1_lat_pc", bus.inst_pc, 32'h3000);
    wait_rx(3, "t1_rx_timeout");
    for (int i = 0; i < 3; i++) begin
      check("t1_rx_pc", rx_pc[i], 32'h3000 + 32'(4 * i));
      check("t1_rx_inst", rx_inst[i], 32'h3000 + 32'(4 * i));
    end

    // Decode stalled: buffer fills to DEPTH, then requests stop.
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (10) cyc();
    check("t2_req_count", 32'(reqlog.size()), 32'd2);
    check("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("t2_head_pc", bus.inst_pc, 32'h3000);
    bus.inst_ready = 1'b1;
    wait_rx(4, "t2_rx_timeout");
    check("t2_rx0", rx_pc[0], 32'h3000);
    check("t2_rx1", rx_pc[1], 32'h3004);
    check("t2_rx2", rx_pc[2], 32'h3008);
    check("t2_rx3", rx_pc[3], 32'h300C);
    check("t2_req2", reqlog[2], 32'h3008);

    // Redirect while waiting on 0x3004 (slow memory): word dropped.
    rsp_delay = 2;
    do_reset();
    wait_hs(32'h3004, "t3_hs3004");
    bus.npc_in = 32'h3100;
    bus.npc_load = 1'b1;
    cyc();
    bus.npc_load = 1'b0;
    check("t3_drop_no_req", 32'(bus.imem_req_valid), 32'd0);
    wait_rx(2, "t3_rx_timeout");
    check("t3_rx0", rx_pc[0], 32'h3000);
    check("t3_rx1_pc", rx_pc[1], 32'h3100);
    check("t3_rx1_inst", rx_inst[1], 32'h3100);
    check("t3_req_after", reqlog[2], 32'h3100);

    // Redirect coinciding with the 0x3008 request handshake; same-cycle pop of 0x3004 kept.
    rsp_delay = 0;
    do_reset();
    wait_req(32'h3008, "t4_req3008");
    bus.npc_in = 32'h3040;
    bus.npc_load = 1'b1;
    cyc();
    bus.npc_load = 1'b0;
    wait_rx(3, "t4_rx_timeout");
    check("t4_rx1", rx_pc[1], 32'h3004);
    check("t4_rx2", rx_pc[2], 32'h3040);
    check("t4_req3", reqlog[3], 32'h3040);

    // Memory not ready: request held stable.
    bus.imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t5_hold_vld", 32'(bus.imem_req_valid), 32'd1);
      check("t5_hold_addr", bus.imem_addr, 32'h3000);
    end

    // Reset asserted while waiting, with one word buffered.
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b0;
    rsp_delay = 3;
    wait_hs(32'h3004, "t5_hs3004");
    check("t5_pre_valid", 32'(bus.inst_valid), 32'd1);
    check("t5_pre_pc", bus.inst_pc, 32'h3000);
    reset_n = 1'b0;
    #1;
    check("t5_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("t5_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("t5_rst_inst_pc", bus.inst_pc, 32'd0);
    check("t5_rst_inst", bus.inst, 32'd0);
    bus.inst_ready = 1'b1;
    rsp_delay = 0;
    do_reset();
    wait_reqs(1, "t5_restart_timeout");
    check("t5_restart_addr", reqlog[0], 32'h3000);

    // Misaligned redirect.
    do_reset();
    wait_rx(1, "t6_rx_timeout");
    bus.npc_in = 32'h3102;
    bus.npc_load = 1'b1;
    cyc();
    bus.npc_load = 1'b0;
    n_before = reqlog.size();
    repeat (10) cyc();
`ifdef PC_FETCH_ALIGN_CHK_EN
    check("t6_fetch_err", 32'(bus.fetch_err), 32'd1);
    check("t6_no_reqs", 32'(reqlog.size()), 32'(n_before));
    check("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
`else
    check("t6_fetch_err", 32'(bus.fetch_err), 32'd0);
    check("t6_more_reqs", 32'(reqlog.size() > n_before), 32'd1);
    check("t6_masked_addr", reqlog[n_before], 32'h3100);
`endif

    // Redirect to the top word: address wraps to 0.
    do_reset();
    bus.npc_in = 32'hFFFF_FFFC;
    bus.npc_load = 1'b1;
    cyc();
    bus.npc_load = 1'b0;
    wait_reqs(3, "t7_req_timeout");
    wait_rx(2, "t7_rx_timeout");
    check("t7_req_top", reqlog[1], 32'hFFFF_FFFC);
    check("t7_req_wrap", reqlog[2], 32'h0000_0000);
    check("t7_rx_top", rx_pc[0], 32'hFFFF_FFFC);
    check("t7_rx_wrap", rx_pc[1], 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
